// File: rtl/fifo_thr.sv
// fifo_thr: synchronous show-ahead FIFO with occupancy thresholds and sticky error flags.
//
// Parameters:
//   WIDTH  - data word width in bits (>=1)
//   DEPTH  - entry capacity (>=2, any value, not limited to powers of two)
//   AF_THR - almost_full asserted when count >= AF_THR (1..DEPTH)
//   AE_THR - almost_empty asserted when count <= AE_THR (0..DEPTH-1)
//
// Ports:
//   clock        in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset (overrides flush/push/pop)
//   flush        in   synchronous discard of all entries (overrides push/pop)
//   push         in   write request
//   wdata        in   write data, captured when the push is accepted
//   pop          in   read request, consumes the head entry
//   rdata        out  head entry, meaningful only while not_empty
//   not_empty    out  count != 0
//   full         out  count == DEPTH
//   almost_full  out  count >= AF_THR
//   almost_empty out  count <= AE_THR
//   count        out  current occupancy
//   overflow     out  sticky, a push was rejected
//   underflow    out  sticky, a pop arrived while empty
module fifo_thr #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AF_THR = DEPTH - 1,
  parameter int unsigned AE_THR = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  // Storage and pointer state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  // Registered status
  logic [CNT_W-1:0] r_count;
  logic             r_not_empty;
  logic             r_full;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;

  // Handshake qualification and next-state values
  logic             w_pop_ok;
  logic             w_push_ok;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic             w_overflow_nxt;
  logic             w_underflow_nxt;

  // Pointer increment that wraps at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is still accepted when a pop frees the head slot.
  assign w_pop_ok  = pop && r_not_empty;
  assign w_push_ok = push && (!r_full || w_pop_ok);

  // Next occupancy, pointers and sticky flags; flush wins over push/pop.
  always_comb begin
    w_cnt_nxt       = r_count;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    if (flush) begin
      w_cnt_nxt       = '0;
      w_wr_ptr_nxt    = '0;
      w_rd_ptr_nxt    = '0;
      w_overflow_nxt  = 1'b0;
      w_underflow_nxt = 1'b0;
    end else begin
      if (w_push_ok) begin
        w_wr_ptr_nxt = f_ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        w_rd_ptr_nxt = f_ptr_inc(r_rd_ptr);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
        2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
        default: w_cnt_nxt = r_count;
      endcase
      if (push && !w_push_ok) begin
        w_overflow_nxt = 1'b1;
      end
      if (pop && !r_not_empty) begin
        w_underflow_nxt = 1'b1;
      end
    end
  end

  // Control state; status flags are registered from the next count so they
  // never depend combinationally on push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_not_empty    <= 1'b0;
      r_full         <= 1'b0;
      r_almost_full  <= (AF_THR == 0);
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_cnt_nxt;
      r_not_empty    <= (w_cnt_nxt != '0);
      r_full         <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_almost_full  <= (w_cnt_nxt >= CNT_W'(AF_THR));
      r_almost_empty <= (w_cnt_nxt <= CNT_W'(AE_THR));
      r_overflow     <= w_overflow_nxt;
      r_underflow    <= w_underflow_nxt;
    end
  end

  // Storage array is never cleared; reset and flush only move the pointers.
  always_ff @(posedge clock) begin
    if (!reset && !flush && w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Show-ahead head entry, read from registered storage and pointer only.
  assign rdata        = r_mem[r_rd_ptr];
  assign not_empty    = r_not_empty;
  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_thr.sv
// tb_fifo_thr: drives a 4-deep and a 3-deep fifo_thr with shared stimulus and
// checks both against queue-based reference models every cycle, plus literal
// expectations for the directed scenarios.
module tb_fifo_thr;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       push;
  logic [7:0] wdata;
  logic       pop;

  logic [7:0] rd4, rd3;
  logic       ne4, fu4, af4, ae4, ov4, un4;
  logic       ne3, fu3, af3, ae3, ov3, un3;
  logic [2:0] c4;
  logic [1:0] c3;

  int total = 0;
  int bad   = 0;

  fifo_thr #(.WIDTH(8), .DEPTH(4), .AF_THR(3), .AE_THR(1)) u_d4 (
    .clock(clk), .reset(reset), .flush(flush), .push(push), .wdata(wdata),
    .pop(pop), .rdata(rd4), .not_empty(ne4), .full(fu4), .almost_full(af4),
    .almost_empty(ae4), .count(c4), .overflow(ov4), .underflow(un4)
  );

  fifo_thr #(.WIDTH(8), .DEPTH(3), .AF_THR(2), .AE_THR(1)) u_d3 (
    .clock(clk), .reset(reset), .flush(flush), .push(push), .wdata(wdata),
    .pop(pop), .rdata(rd3), .not_empty(ne3), .full(fu3), .almost_full(af3),
    .almost_empty(ae3), .count(c3), .overflow(ov3), .underflow(un3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference models: plain queues holding the stored words in order.
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  bit ovf4, unf4, ovf3, unf3;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    bit pok, wok;
    if (reset) begin
      q4.delete(); q3.delete();
      ovf4 = 0; unf4 = 0; ovf3 = 0; unf3 = 0;
      model_ok = 1'b1;
    end else if (flush) begin
      q4.delete(); q3.delete();
      ovf4 = 0; unf4 = 0; ovf3 = 0; unf3 = 0;
    end else begin
      pok = pop && (q4.size() > 0);
      wok = push && ((q4.size() < 4) || pok);
      if (push && !wok) ovf4 = 1;
      if (pop && q4.size() == 0) unf4 = 1;
      if (pok) void'(q4.pop_front());
      if (wok) q4.push_back(wdata);

      pok = pop && (q3.size() > 0);
      wok = push && ((q3.size() < 3) || pok);
      if (push && !wok) ovf3 = 1;
      if (pop && q3.size() == 0) unf3 = 1;
      if (pok) void'(q3.pop_front());
      if (wok) q3.push_back(wdata);
    end
  end

  // Compare both DUTs against their models on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      cmp("d4_count", 32'(c4), 32'(q4.size()));
      cmp("d4_not_empty", 32'(ne4), 32'(q4.size() != 0));
      cmp("d4_full", 32'(fu4), 32'(q4.size() == 4));
      cmp("d4_almost_full", 32'(af4), 32'(q4.size() >= 3));
      cmp("d4_almost_empty", 32'(ae4), 32'(q4.size() <= 1));
      cmp("d4_overflow", 32'(ov4), 32'(ovf4));
      cmp("d4_underflow", 32'(un4), 32'(unf4));
      if (q4.size() > 0) cmp("d4_rdata", 32'(rd4), 32'(q4[0]));

      cmp("d3_count", 32'(c3), 32'(q3.size()));
      cmp("d3_not_empty", 32'(ne3), 32'(q3.size() != 0));
      cmp("d3_full", 32'(fu3), 32'(q3.size() == 3));
      cmp("d3_almost_full", 32'(af3), 32'(q3.size() >= 2));
      cmp("d3_almost_empty", 32'(ae3), 32'(q3.size() <= 1));
      cmp("d3_overflow", 32'(ov3), 32'(ovf3));
      cmp("d3_underflow", 32'(un3), 32'(unf3));
      if (q3.size() > 0) cmp("d3_rdata", 32'(rd3), 32'(q3[0]));
    end
  end

  // One clock of stimulus; inputs return to idle afterwards.
  task automatic step(input bit p, input logic [7:0] w, input bit pp, input bit f, input bit r);
    push = p; wdata = w; pop = pp; flush = f; reset = r;
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0; reset = 0;
  endtask

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    push = 0; pop = 0; flush = 0; wdata = '0; reset = 1;
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Post-reset state
    cmp("rst_count", 32'(c4), 32'd0);
    cmp("rst_not_empty", 32'(ne4), 32'd0);
    cmp("rst_full", 32'(fu4), 32'd0);
    cmp("rst_almost_full", 32'(af4), 32'd0);
    cmp("rst_almost_empty", 32'(ae4), 32'd1);
    cmp("rst_overflow", 32'(ov4), 32'd0);

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      step(1, fill[i], 0, 0, 0);
      cmp("fill_count", 32'(c4), 32'(i + 1));
      cmp("fill_almost_full", 32'(af4), 32'(i >= 2));
      cmp("fill_full", 32'(fu4), 32'(i == 3));
    end
    for (int i = 0; i < 4; i++) begin
      cmp("drain_rdata", 32'(rd4), 32'(fill[i]));
      step(0, 8'h00, 1, 0, 0);
      cmp("drain_almost_empty", 32'(ae4), 32'(i >= 2));
    end
    cmp("drain_not_empty", 32'(ne4), 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) step(1, fill[i], 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    cmp("fullpp_count", 32'(c4), 32'd4);
    cmp("fullpp_overflow", 32'(ov4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cmp("fullpp_rdata", 32'(rd4), (i == 3) ? 32'h55 : 32'(fill[i + 1 > 3 ? 3 : i + 1]));
      step(0, 8'h00, 1, 0, 0);
    end

    // Overflow and underflow stickiness
    for (int i = 0; i < 4; i++) step(1, fill[i], 0, 0, 0);
    step(1, 8'h66, 0, 0, 0);
    cmp("ovf_flag", 32'(ov4), 32'd1);
    cmp("ovf_count", 32'(c4), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cmp("ovf_rdata", 32'(rd4), 32'(fill[i]));
      step(0, 8'h00, 1, 0, 0);
    end
    step(0, 8'h00, 1, 0, 0);
    cmp("unf_flag", 32'(un4), 32'd1);
    cmp("unf_count", 32'(c4), 32'd0);
    step(0, 8'h00, 0, 0, 0);
    cmp("hold_overflow", 32'(ov4), 32'd1);
    cmp("hold_underflow", 32'(un4), 32'd1);
    step(0, 8'h00, 0, 1, 0);
    cmp("flush_overflow", 32'(ov4), 32'd0);
    cmp("flush_underflow", 32'(un4), 32'd0);

    // Pointer wrap with steady occupancy of two
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h01, 0, 0, 0);
    for (int i = 2; i < 10; i++) begin
      cmp("wrap_rdata", 32'(rd4), 32'(i - 2));
      step(1, 8'(i), 1, 0, 0);
      cmp("wrap_count", 32'(c4), 32'd2);
    end
    for (int i = 8; i < 10; i++) begin
      cmp("wrap_tail", 32'(rd4), 32'(i));
      step(0, 8'h00, 1, 0, 0);
    end

    // Flush overrides push and pop
    for (int i = 0; i < 3; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0);
    cmp("fpri_pre_count", 32'(c4), 32'd3);
    step(1, 8'hEE, 1, 1, 0);
    cmp("fpri_count", 32'(c4), 32'd0);
    cmp("fpri_not_empty", 32'(ne4), 32'd0);
    cmp("fpri_flags", 32'({ov4, un4}), 32'd0);
    step(1, 8'hA5, 0, 0, 0);
    cmp("fpri_rdata", 32'(rd4), 32'hA5);

    // Reset mid-stream, then the depth-3 instance across its wrap
    step(0, 8'h00, 0, 0, 1);
    cmp("mrst_count", 32'(c4), 32'd0);
    cmp("mrst_not_empty", 32'(ne4), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 0, 0, 0);
    cmp("d3_full_lit", 32'(fu3), 32'd1);
    cmp("d3_count_lit", 32'(c3), 32'd3);
    cmp("d4_not_full_lit", 32'(fu4), 32'd0);
    for (int k = 0; k < 7; k++) begin
      cmp("d3_wrap_rdata", 32'(rd3), 32'h30 + 32'(k));
      step(1, 8'h33 + 8'(k), 1, 0, 0);
      cmp("d3_wrap_count", 32'(c3), 32'd3);
    end

    // Randomised traffic with alternating fill and drain bias
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i % 400) < 200) ? 75 : 30;
      step(($urandom_range(99) < bias), 8'($urandom),
           ($urandom_range(99) < (100 - bias)),
           ($urandom_range(63) == 0), ($urandom_range(255) == 0));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
